qrd_input_skew: RTL

//  Parametrised input-staggering front end for the QRD-RLS systolic array.
//  - Takes N_CH parallel samples per step: N_CH-1 array-column inputs plus the desired signal sk.
//  - Skews them so column k reaches the array k+1 advance steps after acceptance.
//  - Adds per-channel valid tags, a stall handshake and drain status.
//  - Sits between the sample source and the BC/IC systolic core.

---
 rtl/qrd_input_skew.sv | 84 ++++++++
 1 files changed

// File: rtl/qrd_input_skew.sv
// ============================================================================
// Module   : qrd_input_skew
// Desc     : Input staggering front end for the QRD-RLS systolic array; column k
//            is delayed k+1 steps, sk by SK_DELAY. Optional SKEW_SAMPLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qrd_input_skew #(
    parameter int DATA_LENGTH = 8,
    parameter int N_CH        = 4,
    parameter int SK_DELAY    = 1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH*DATA_LENGTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        array_ready,
    output logic [N_CH*DATA_LENGTH-1:0] out_data,
    output logic [N_CH-1:0]             out_valid,
`ifdef SKEW_SAMPLE_CNT_EN
    output logic [CNT_W-1:0]            sample_cnt,
`endif
    output logic                        busy
);

    logic [N_CH-1:0] w_ch_busy;

    assign in_ready = array_ready;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_chain
            localparam int c_depth = (k == N_CH-1) ? SK_DELAY : k + 1;

            logic [c_depth-1:0]     r_v;
            logic [DATA_LENGTH-1:0] r_d [c_depth];

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_v <= '0;
                    for (int j = 0; j < c_depth; j++) begin
                        r_d[j] <= '0;
                    end
                end else if (array_ready) begin
                    // Bubbles carry zero data so idle outputs read clean.
                    r_v[0] <= in_valid;
                    r_d[0] <= in_valid ? in_data[k*DATA_LENGTH +: DATA_LENGTH] : '0;
                    for (int j = 1; j < c_depth; j++) begin
                        r_v[j] <= r_v[j-1];
                        r_d[j] <= r_d[j-1];
                    end
                end
            end

            assign out_data[k*DATA_LENGTH +: DATA_LENGTH] = r_d[c_depth-1];
            assign out_valid[k]                           = r_v[c_depth-1];
            assign w_ch_busy[k]                           = |r_v;
        end
    endgenerate

    // Every tag lives in a flop, so this is a pure function of state.
    assign busy = |w_ch_busy;

`ifdef SKEW_SAMPLE_CNT_EN
    localparam int c_deep_ch = (SK_DELAY > N_CH-1) ? N_CH-1 : N_CH-2;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (array_ready && out_valid[c_deep_ch]) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sample_cnt = r_cnt;
`endif

endmodule

`default_nettype wire
